// File: rtl/axi_rd_arb_pkg.sv
// Shared definitions for the LSU read-command arbiter.
// Contents:
//   state_t       - arbiter FSM state encoding
//   *_LSB / *_W   - bit positions of the fields in a packed requester command
//   arid_lsb()    - position of the id field, which sits above the AW-wide address
// Packed command layout, MSB first:
//   {id8, araddr AW, arlen8, arsize3, arburst2, arstr3, sram_addr12, arnum8}
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ARNUM_LSB   = 0;
  localparam int ARNUM_W     = 8;
  localparam int SRAM_LSB    = 8;
  localparam int SRAM_W      = 12;
  localparam int ARSTR_LSB   = 20;
  localparam int ARSTR_W     = 3;
  localparam int ARBURST_LSB = 23;
  localparam int ARBURST_W   = 2;
  localparam int ARSIZE_LSB  = 25;
  localparam int ARSIZE_W    = 3;
  localparam int ARLEN_LSB   = 28;
  localparam int ARLEN_W     = 8;
  localparam int ARADDR_LSB  = 36;
  localparam int ARID_W      = 8;

  // Command width excluding the address field; full width is CMD_FIXED_W + AW.
  localparam int CMD_FIXED_W = 44;
  localparam int AW_DEFAULT  = 10;

  function automatic int arid_lsb(input int aw);
    return ARADDR_LSB + aw;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// Round-robin picker: finds the first asserted request at or above ptr,
// wrapping modulo NREQ. Purely combinational.
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IW    index with highest priority this cycle
//   onehot out NREQ  one-hot winner (all zero when no request)
//   idx    out IW    winner index (0 when no request)
//   any    out 1     at least one request present
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Walk offsets from farthest to nearest so the candidate closest to ptr
  // is the last one written and therefore wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      for (int c = 0; c < NREQ; c++) begin
        if (req[c] && (c == (int'(ptr) + off) % NREQ)) begin
          onehot    = '0;
          onehot[c] = 1'b1;
          idx       = IW'(c);
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares the single LSU read-command port among NREQ load requesters.
// A round-robin grant is held for a whole job: the command is issued once,
// every returned beat is steered to the granted requester, and the grant is
// released on the read interface's done indication or on a beat timeout.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_vld/req_cmd        per-requester command valid / packed command
//   req_rdy                one-hot command accept pulse
//   req_rvld/req_rrdy      per-requester beat valid / ready (granted one only)
//   req_done/req_err       one-cycle job-complete / timeout pulses
//   rd_rdata/rresp/sram    beat payload broadcast to all requesters
//   lsu_axi_ar*/arvld      command towards the read interface
//   axi_lsu_arrdy          read interface accepts the command
//   axi_lsu_rvld/r*        beat from the read interface, lsu_axi_rrdy back
//   axi_lsu_axi_done       all bursts of the current job returned
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = AW_DEFAULT,
  parameter int TIMEOUT = 1024,
  parameter int CMD_W   = CMD_FIXED_W + AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  output logic [NREQ-1:0]       req_rdy,
  output logic [NREQ-1:0]       req_rvld,
  input  logic [NREQ-1:0]       req_rrdy,
  output logic [NREQ-1:0]       req_done,
  output logic [NREQ-1:0]       req_err,
  output logic [63:0]           rd_rdata,
  output logic [1:0]            rd_rresp,
  output logic [11:0]           rd_sram_addr,
  output logic [7:0]            lsu_axi_arid,
  output logic [AW-1:0]         lsu_axi_araddr,
  output logic [7:0]            lsu_axi_arlen,
  output logic [2:0]            lsu_axi_arsize,
  output logic [1:0]            lsu_axi_arburst,
  output logic [2:0]            lsu_axi_arstr,
  output logic [11:0]           lsu_axi_sram_addr,
  output logic [7:0]            lsu_axi_arnum,
  output logic                  lsu_axi_arvld,
  input  logic                  axi_lsu_arrdy,
  input  logic                  axi_lsu_rvld,
  input  logic [63:0]           axi_lsu_rdata,
  input  logic [1:0]            axi_lsu_rresp,
  input  logic [11:0]           axi_lsu_sram_addr,
  output logic                  lsu_axi_rrdy,
  input  logic                  axi_lsu_axi_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_t            state_reg;
  logic [IW-1:0]     rr_ptr_reg;
  logic [IW-1:0]     grant_reg;
  logic [CMD_W-1:0]  cmd_reg;
  logic [CW-1:0]     cnt_reg;
  logic              first_reg;   // first WAIT cycle: stale done is ignored
  logic [NREQ-1:0]   done_reg;

  logic [CMD_W-1:0]  cmd_slice [NREQ];
  logic [NREQ-1:0]   pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [NREQ-1:0]   grant_onehot;
  logic [IW-1:0]     next_ptr;
  logic              in_wait;
  logic              beat_hs;
  logic              go_done;
  logic              timeout_hit;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign cmd_slice[gi] = req_cmd[gi*CMD_W +: CMD_W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req_vld),
    .ptr    (rr_ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign grant_onehot = NREQ'(1) << grant_reg;
  assign next_ptr     = (grant_reg == IW'(NREQ - 1)) ? '0 : grant_reg + 1'b1;
  assign in_wait      = (state_reg == ST_WAIT);
  assign lsu_axi_rrdy = in_wait & req_rrdy[grant_reg];
  assign beat_hs      = axi_lsu_rvld & lsu_axi_rrdy;
  // A pending beat defers completion until it has been handed over.
  assign go_done      = in_wait & ~first_reg & axi_lsu_axi_done & ~axi_lsu_rvld;
  assign timeout_hit  = in_wait & ~go_done & ~beat_hs & (cnt_reg == CNT_MAX);

  assign req_rdy  = (state_reg == ST_IDLE && pick_any && !rst) ? pick_onehot : '0;
  assign req_err  = (timeout_hit && !rst) ? grant_onehot : '0;
  assign req_done = done_reg;
  assign req_rvld = (in_wait && axi_lsu_rvld) ? grant_onehot : '0;

  assign rd_rdata     = in_wait ? axi_lsu_rdata : '0;
  assign rd_rresp     = in_wait ? axi_lsu_rresp : '0;
  assign rd_sram_addr = in_wait ? axi_lsu_sram_addr : '0;

  assign lsu_axi_arvld     = (state_reg == ST_ISSUE);
  assign lsu_axi_arid      = cmd_reg[arid_lsb(AW) +: ARID_W];
  assign lsu_axi_araddr    = cmd_reg[ARADDR_LSB +: AW];
  assign lsu_axi_arlen     = cmd_reg[ARLEN_LSB +: ARLEN_W];
  assign lsu_axi_arsize    = cmd_reg[ARSIZE_LSB +: ARSIZE_W];
  assign lsu_axi_arburst   = cmd_reg[ARBURST_LSB +: ARBURST_W];
  assign lsu_axi_arstr     = cmd_reg[ARSTR_LSB +: ARSTR_W];
  assign lsu_axi_sram_addr = cmd_reg[SRAM_LSB +: SRAM_W];
  assign lsu_axi_arnum     = cmd_reg[ARNUM_LSB +: ARNUM_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      cmd_reg    <= '0;
      cnt_reg    <= '0;
      first_reg  <= 1'b0;
      done_reg   <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            grant_reg <= pick_idx;
            cmd_reg   <= cmd_slice[pick_idx];
            // A job with no bursts completes without touching the bus.
            state_reg <= (cmd_slice[pick_idx][ARNUM_LSB +: ARNUM_W] == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (axi_lsu_arrdy) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= '0;
            first_reg <= 1'b1;
          end
        end
        ST_WAIT: begin
          first_reg <= 1'b0;
          if (beat_hs) begin
            cnt_reg <= '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (go_done) begin
            state_reg <= ST_DONE;
          end else if (timeout_hit) begin
            rr_ptr_reg <= next_ptr;
            state_reg  <= ST_IDLE;
          end
        end
        ST_DONE: begin
          done_reg   <= grant_onehot;
          rr_ptr_reg <= next_ptr;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single LSU-side read-command port of the AXI read interface among NREQ load requesters (weight, activation, bias loaders).
- Round-robin grant, held for the whole multi-burst job: one command issued, all beats routed back, completion waited for.
- Sits between the loaders and the AXI read interface. Owns command sequencing and response steering.

Parameters:
- NREQ, 2, number of requesters (2..4)
- AW, 10, DRAM read address width (matches ARADDR width)
- TIMEOUT, 1024, idle cycles in WAIT with no beat before an error is flagged
- CMD_W, 44+AW, packed command width (layout in package)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_vld  in  NREQ  per-requester command valid
- req_cmd  in  NREQ*CMD_W  per-requester packed command {id8,araddr AW,arlen8,arsize3,arburst2,arstr3,sram_addr12,arnum8}, requester 0 in LSBs
- req_rdy  out  NREQ  one-hot accept pulse
- req_rvld  out  NREQ  beat valid, only the granted bit can be set
- req_rrdy  in  NREQ  per-requester beat ready
- req_done  out  NREQ  one-cycle job-complete pulse
- req_err  out  NREQ  one-cycle timeout pulse
- rd_rdata  out  64  beat data, broadcast
- rd_rresp  out  2  beat response, broadcast
- rd_sram_addr  out  12  SRAM destination of beat, broadcast
- lsu_axi_arid/araddr/arlen/arsize/arburst/arstr/sram_addr/arnum  out  8/AW/8/3/2/3/12/8  command to read interface
- lsu_axi_arvld  out  1  command valid
- axi_lsu_arrdy  in  1  read interface idle/ready
- axi_lsu_rvld  in  1  beat valid from read interface
- axi_lsu_rdata/rresp/sram_addr  in  64/2/12  beat payload
- lsu_axi_rrdy  out  1  beat ready to read interface
- axi_lsu_axi_done  in  1  all bursts of current job returned

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: FSM=IDLE, rr_ptr=0, grant=0, cmd regs=0, timeout cnt=0. All outputs 0.
- Reset mid-job drops the job silently; no done/err is produced.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_vld, pick the first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Same cycle: req_rdy[winner]=1, latch req_cmd slice, grant=winner.
  - If latched arnum==0 go DONE (no AXI traffic); else go ISSUE.
  - With no req_vld, stay in IDLE.
- ISSUE:
  - lsu_axi_arvld=1 with latched fields, held stable.
  - When axi_lsu_arrdy=1, the command is accepted that cycle; go WAIT next.
- WAIT:
  - lsu_axi_arvld=0.
  - req_rvld[grant]=axi_lsu_rvld; lsu_axi_rrdy=req_rrdy[grant]. Both are combinational pass-through with 0 added latency.
  - rd_* mirror axi_lsu_* combinationally.
  - Done is ignored in the first WAIT cycle (read interface clears its counter on accept).
  - From the second WAIT cycle: if axi_lsu_axi_done=1 and axi_lsu_rvld=0, go DONE.
  - If done and rvld are both high, finish the beat first.
  - Timeout cnt clears on every beat handshake and on WAIT entry, and increments otherwise, saturating.
  - When cnt reaches TIMEOUT-1: pulse req_err[grant], go IDLE, rr_ptr=grant+1. No done pulse is given.
- DONE: req_done[grant]=1 for one cycle, rr_ptr=(grant+1) mod NREQ, go IDLE.
- Back-to-back throughput: a new grant in IDLE can occur the cycle after DONE.
- Non-granted requesters never see rvld, rdy or done. Their req_vld may stay high indefinitely.
- req_cmd is sampled only in the req_rdy cycle; later changes are ignored.
- Beats arriving outside WAIT are protocol violations: lsu_axi_rrdy=0 outside WAIT.

Decomposition:
- Package axi_rd_arb_pkg: CMD_W, field offsets/widths of packed command, state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3).
- One sub-module: rr_pick (NREQ request vector + rr_ptr -> one-hot winner + index, combinational).

Test Plan:
- Single job: req_vld=01, arnum=3, 3 beats with rlast, done after 3rd → lsu_axi_arvld for 1 cycle with arrdy=1, req_rvld[0] on each beat, req_done=01 one cycle, req_rvld[1] never set.
- Contention: req_vld=11 from reset → req0 granted first; after its done, req1 granted next cycle with its own araddr (e.g. 0x040 vs 0x100); then req0 again (fairness).
- Backpressure: req_rrdy[grant]=0 for 4 cycles during beat → lsu_axi_rrdy=0, rdata held stable, no timeout; done deferred while rvld pending.
- arnum=0 command → req_rdy then req_done two cycles later, lsu_axi_arvld never asserted.
- Timeout: TIMEOUT=16, no beats after issue → req_err[grant] pulses at 16th WAIT cycle, FSM IDLE, next requester granted.
- rst asserted in WAIT with beat pending → next cycle all outputs 0, no done/err; new request accepted after rst drops, starting at requester 0.
